// File: rtl/adler32_stream.sv
// Streaming Adler-32 checksum over byte beats of LANES bytes.
// Holds one result until the consumer takes it, then reopens for the next message.
module adler32_stream #(
    parameter int LANES = 1,
    parameter int LEN_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_keep,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_checksum,
    output logic [LEN_W-1:0]     out_len
);

    localparam logic [16:0] MOD = 17'd65521;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d, b_q, b_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        sum_q, sum_d;
    logic [LEN_W-1:0]   olen_q, olen_d;

    logic               accept;
    logic [16:0]        a_acc, b_acc;
    logic [LEN_W-1:0]   len_base, cnt;

    // Per-byte fold: both sums stay below 2*MOD, so one conditional subtract reduces each.
    always_comb begin
        a_acc    = (state_q == IDLE) ? 17'd1 : {1'b0, a_q};
        b_acc    = (state_q == IDLE) ? 17'd0 : {1'b0, b_q};
        len_base = (state_q == IDLE) ? '0 : len_q;
        cnt      = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!in_last || in_keep[i]) begin
                a_acc = a_acc + {9'd0, in_data[8*i +: 8]};
                if (a_acc >= MOD) a_acc = a_acc - MOD;
                b_acc = b_acc + a_acc;
                if (b_acc >= MOD) b_acc = b_acc - MOD;
                cnt = cnt + LEN_W'(1);
            end
        end
    end

    assign in_ready  = !rst && (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        len_d   = len_q;
        sum_d   = sum_q;
        olen_d  = olen_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    a_d   = a_acc[15:0];
                    b_d   = b_acc[15:0];
                    len_d = len_base + cnt;
                    if (in_last) begin
                        state_d = DONE;
                        sum_d   = {b_acc[15:0], a_acc[15:0]};
                        olen_d  = len_base + cnt;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 16'd1;
            b_q     <= 16'd0;
            len_q   <= '0;
            sum_q   <= '0;
            olen_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            olen_q  <= olen_d;
        end
    end

    assign out_checksum = sum_q;
    assign out_len      = olen_q;

endmodule

// File: tb/tb_adler32_stream.sv
// Bench for adler32_stream: one LANES=1 and one LANES=4 instance, checked every cycle
// against a byte-queue Adler-32 model, plus literal expectations for known messages.
module tb_adler32_stream;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic        in_valid [2];
    logic        in_last  [2];
    logic        out_ready[2];
    logic        in_ready [2];
    logic        out_valid[2];
    logic [31:0] in_data  [2];
    logic [3:0]  in_keep  [2];
    logic [31:0] out_checksum[2];
    logic [31:0] out_len  [2];

    logic [63:0] exp0[$];
    logic [63:0] exp1[$];

    int checks   = 0;
    int failures = 0;

    adler32_stream #(.LANES(1), .LEN_W(32)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0][7:0]), .in_keep(in_keep[0][0:0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_checksum(out_checksum[0]), .out_len(out_len[0])
    );

    adler32_stream #(.LANES(4), .LEN_W(32)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_keep(in_keep[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_checksum(out_checksum[1]), .out_len(out_len[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout/unexpected event, expected in-bound response", name);
    endtask

    // Reference Adler-32 over a whole message.
    function automatic logic [31:0] adler(input bq_t q);
        int unsigned a = 1;
        int unsigned b = 0;
        foreach (q[i]) begin
            a = (a + q[i]) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Every-cycle comparison against the model.
    task automatic compare_one(input int d);
        logic [63:0] front;
        int          qsize;
        qsize = (d == 0) ? exp0.size() : exp1.size();
        if (rst) begin
            check($sformatf("reset_outputs_d%0d", d),
                  {30'd0, in_ready[d], out_valid[d], out_checksum[d]}, 64'd0);
            check($sformatf("reset_len_d%0d", d), {32'd0, out_len[d]}, 64'd0);
        end else begin
            check($sformatf("in_ready_vs_done_d%0d", d), {63'd0, in_ready[d]}, {63'd0, !out_valid[d]});
            if (out_valid[d]) begin
                if (qsize == 0) begin
                    fail_now($sformatf("spurious_out_valid_d%0d", d));
                end else begin
                    front = (d == 0) ? exp0[0] : exp1[0];
                    check($sformatf("result_vs_model_d%0d", d), {out_checksum[d], out_len[d]}, front);
                    if (out_ready[d]) begin
                        if (d == 0) void'(exp0.pop_front());
                        else        void'(exp1.pop_front());
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_one(0);
            compare_one(1);
        end
    end

    // Sends msg as beats on instance d; term=0 leaves the message open.
    task automatic send_msg(input int d, input bq_t msg, input bit gap, input bit term);
        int          lanes;
        int          n;
        int          beats;
        int          idx;
        int          cnt;
        int          w;
        logic [31:0] data;
        logic [3:0]  keep;
        lanes = (d == 1) ? 4 : 1;
        n     = msg.size();
        beats = (n == 0) ? 1 : (n + lanes - 1) / lanes;
        idx   = 0;
        @(posedge clk);
        #1;
        for (int bt = 0; bt < beats; bt++) begin
            cnt  = (n - idx < lanes) ? n - idx : lanes;
            data = $urandom();
            keep = 4'd0;
            for (int l = 0; l < cnt; l++) begin
                data[8*l +: 8] = msg[idx + l];
                keep[l]        = 1'b1;
            end
            if (bt != beats - 1) keep = 4'($urandom());
            idx = idx + cnt;
            in_valid[d] = 1'b1;
            in_data[d]  = data;
            in_keep[d]  = keep;
            in_last[d]  = term && (bt == beats - 1);
            w = 0;
            @(negedge clk);
            while (!in_ready[d] && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready[d]) begin
                fail_now($sformatf("in_ready_timeout_d%0d", d));
                in_valid[d] = 1'b0;
                return;
            end
            @(posedge clk);
            if (term && bt == beats - 1) begin
                if (d == 0) exp0.push_back({adler(msg), 32'(n)});
                else        exp1.push_back({adler(msg), 32'(n)});
            end
            #1;
            if (gap) begin
                in_valid[d] = 1'b0;
                in_data[d]  = $urandom();
                in_keep[d]  = 4'($urandom());
                in_last[d]  = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
        if (term && !gap) begin
            @(negedge clk);
            check($sformatf("latency_one_cycle_d%0d", d), {63'd0, out_valid[d]}, 64'd1);
        end
    endtask

    // Waits for a result, pins it to a literal, holds it for `hold` cycles, then takes it.
    task automatic recv(input int d, input logic [31:0] lit_sum, input logic [31:0] lit_len,
                        input int hold);
        int n = 0;
        @(negedge clk);
        while (!out_valid[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[d]) begin
            fail_now($sformatf("out_valid_timeout_d%0d", d));
            return;
        end
        check($sformatf("literal_checksum_d%0d", d), {32'd0, out_checksum[d]}, {32'd0, lit_sum});
        check($sformatf("literal_len_d%0d", d), {32'd0, out_len[d]}, {32'd0, lit_len});
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check($sformatf("held_checksum_d%0d", d), {32'd0, out_checksum[d]}, {32'd0, lit_sum});
            check($sformatf("held_in_ready_low_d%0d", d), {63'd0, in_ready[d]}, 64'd0);
        end
        @(posedge clk);
        #1 out_ready[d] = 1'b1;
        @(posedge clk);
        #1 out_ready[d] = 1'b0;
        @(negedge clk);
        check($sformatf("ready_after_handshake_d%0d", d), {63'd0, in_ready[d]}, 64'd1);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        exp0.delete();
        exp1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset_d0", {63'd0, in_ready[0]}, 64'd1);
        check("ready_after_reset_d1", {63'd0, in_ready[1]}, 64'd1);
    endtask

    bq_t abc, wiki, ffs, empty, two;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_last[d]   = 1'b0;
            in_data[d]   = '0;
            in_keep[d]   = '0;
            out_ready[d] = 1'b0;
        end
        abc  = str2q("abc");
        wiki = str2q("Wikipedia");
        two  = str2q("xy");
        for (int i = 0; i < 1024; i++) ffs.push_back(8'hFF);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset_d0", {63'd0, in_ready[0]}, 64'd1);
        check("ready_after_reset_d1", {63'd0, in_ready[1]}, 64'd1);

        send_msg(0, abc, 1'b0, 1'b1);
        recv(0, 32'h024D0127, 32'd3, 0);

        send_msg(1, wiki, 1'b0, 1'b1);
        recv(1, 32'h11E60398, 32'd9, 0);

        send_msg(1, ffs, 1'b0, 1'b1);
        recv(1, 32'h79A6FC2E, 32'd1024, 0);

        send_msg(1, empty, 1'b0, 1'b1);
        recv(1, 32'h00000001, 32'd0, 0);
        send_msg(0, empty, 1'b0, 1'b1);
        recv(0, 32'h00000001, 32'd0, 0);

        send_msg(0, wiki, 1'b1, 1'b1);
        recv(0, 32'h11E60398, 32'd9, 0);

        // Result held for 5 cycles while the next message is already being offered.
        send_msg(1, abc, 1'b1, 1'b1);
        fork
            send_msg(1, wiki, 1'b0, 1'b1);
            recv(1, 32'h024D0127, 32'd3, 5);
        join
        recv(1, 32'h11E60398, 32'd9, 0);

        // Pending result on dut4 and a 2-byte open message on dut1 are both discarded.
        send_msg(1, abc, 1'b0, 1'b1);
        send_msg(0, two, 1'b0, 1'b0);
        reset_pulse();
        repeat (3) @(negedge clk);
        send_msg(0, abc, 1'b0, 1'b1);
        recv(0, 32'h024D0127, 32'd3, 0);
        send_msg(1, abc, 1'b0, 1'b1);
        recv(1, 32'h024D0127, 32'd3, 0);

        repeat (4) @(negedge clk);
        check("model_drained_d0", 64'(exp0.size()), 64'd0);
        check("model_drained_d1", 64'(exp1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
